// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the M-stage data-memory controller.
package mips_mem_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam logic [NUM_LANES-1:0] BE_WORD = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    READ  = 2'd2,
    RDONE = 2'd3
  } dmem_state_e;

  function automatic logic [NUM_LANES-1:0] sb_be(input logic [1:0] byte_off);
    return 4'b0001 << byte_off;
  endfunction

endpackage

// File: rtl/store_buffer.sv
// One-entry store buffer: formats sw/sb into a word-aligned bus write and
// holds it until the controller drains it.
module store_buffer
  import mips_mem_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic                 capture_i,
  input  logic                 clear_i,
  input  logic                 sb_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [DW-1:0]        wdata_i,
  output logic                 valid_o,
  output logic [AW-1:0]        addr_o,
  output logic [DW-1:0]        wdata_o,
  output logic [NUM_LANES-1:0] be_o
);

  logic                 valid_q, valid_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [NUM_LANES-1:0] be_q, be_d;

  // Capture wins over clear so a store accepted in the drain-ack cycle survives.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    if (clear_i) valid_d = 1'b0;
    if (capture_i) begin
      valid_d = 1'b1;
      addr_d  = {addr_i[AW-1:2], 2'b00};
      if (sb_i) begin
        be_d    = sb_be(addr_i[1:0]);
        wdata_d = {(DW/8){wdata_i[7:0]}};
      end else begin
        be_d    = BE_WORD;
        wdata_d = wdata_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign be_o    = be_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller for the M stage: buffered stores, blocking loads,
// one outstanding req/ack transaction on the external memory bus.
//
// state | meaning
// IDLE  | bus free; drain a buffered store first, else start a pending load
// DRAIN | buffered store on the bus, waiting for ack
// READ  | load on the bus, waiting for ack
// RDONE | load data in readdataM; the load's completion cycle
module dmem_ctrl
  import mips_mem_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 memreadM,
  input  logic                 memwriteM,
  input  logic                 sbM,
  input  logic [AW-1:0]        aluoutM,
  input  logic [DW-1:0]        writedataM,
  output logic [DW-1:0]        readdataM,
  output logic                 memstallM,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  output logic [NUM_LANES-1:0] mem_be,
  input  logic                 mem_ack,
  input  logic [DW-1:0]        mem_rdata
);

  dmem_state_e          state_q;
  logic                 req_q, we_q;
  logic [AW-1:0]        addr_q;
  logic [DW-1:0]        wdata_q, rdata_q;
  logic [NUM_LANES-1:0] be_q;

  logic                 sb_valid;
  logic [AW-1:0]        sb_addr;
  logic [DW-1:0]        sb_wdata;
  logic [NUM_LANES-1:0] sb_be_q;
  logic                 drain_ack;
  logic                 capture;

  assign drain_ack = (state_q == DRAIN) && mem_ack;

  assign memstallM = (memreadM && (state_q != RDONE)) ||
                     (memwriteM && sb_valid && !drain_ack);

  // A simultaneous read+write is treated purely as a load.
  assign capture = memwriteM && !memreadM && !memstallM;

  store_buffer #(.AW(AW), .DW(DW)) u_store_buffer (
    .clk       (clk),
    .rst_i     (reset),
    .capture_i (capture),
    .clear_i   (drain_ack),
    .sb_i      (sbM),
    .addr_i    (aluoutM),
    .wdata_i   (writedataM),
    .valid_o   (sb_valid),
    .addr_o    (sb_addr),
    .wdata_o   (sb_wdata),
    .be_o      (sb_be_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sb_valid) begin
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            addr_q  <= sb_addr;
            wdata_q <= sb_wdata;
            be_q    <= sb_be_q;
            state_q <= DRAIN;
          end else if (memreadM) begin
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= {aluoutM[AW-1:2], 2'b00};
            be_q    <= BE_WORD;
            state_q <= READ;
          end
        end
        DRAIN: begin
          if (mem_ack) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        READ: begin
          if (mem_ack) begin
            rdata_q <= mem_rdata;
            req_q   <= 1'b0;
            state_q <= RDONE;
          end
        end
        RDONE:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign readdataM = rdata_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus random traffic
// against a word-array reference memory and a program-order bus queue.
module tb_dmem_ctrl;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        memreadM, memwriteM, sbM;
  logic [31:0] aluoutM, writedataM;
  logic [31:0] readdataM;
  logic        memstallM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int fixed_wait = 0;

  logic [31:0] model_mem [int];
  logic [31:0] bus_mem [int];
  bus_t        exp_q [$];

  dmem_ctrl #(.AW(32), .DW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .memreadM   (memreadM),
    .memwriteM  (memwriteM),
    .sbM        (sbM),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .readdataM  (readdataM),
    .memstallM  (memstallM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_word(input logic [31:0] mem [int], input int idx);
    if (mem.exists(idx)) return mem[idx];
    return 32'h0;
  endfunction

  // Memory responder: ack after a chosen number of wait cycles, check bus
  // stability while waiting and the transaction against program order.
  initial begin : responder
    int          cnt;
    int          target;
    logic [68:0] held;
    bus_t        e;
    logic [31:0] w;
    cnt = 0;
    target = 0;
    held = '0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (reset || !mem_req) begin
        cnt = 0;
      end else begin
        if (cnt == 0) begin
          target = (fixed_wait < 0) ? int'($urandom_range(0, 3)) : fixed_wait;
          held = {mem_we, mem_addr, mem_be, mem_wdata};
        end else begin
          checks++;
          if ({mem_we, mem_addr, mem_be, mem_wdata} !== held) begin
            errors++;
            $display("FAIL bus_stable: got %h expected %h", {mem_we, mem_addr, mem_be, mem_wdata}, held);
          end
        end
        if (cnt == target) begin
          cnt = 0;
          mem_ack = 1'b1;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL bus_unexpected: we=%b addr=%h with no access expected", mem_we, mem_addr);
          end else begin
            e = exp_q.pop_front();
            if (mem_we !== e.we || mem_addr !== e.addr ||
                (e.we && (mem_be !== e.be || mem_wdata !== e.wdata))) begin
              errors++;
              $display("FAIL bus_order: got we=%b addr=%h be=%h wdata=%h expected we=%b addr=%h be=%h wdata=%h",
                       mem_we, mem_addr, mem_be, mem_wdata, e.we, e.addr, e.be, e.wdata);
            end
          end
          if (mem_we) begin
            w = rd_word(bus_mem, int'(mem_addr >> 2));
            for (int k = 0; k < 4; k++)
              if (mem_be[k]) w[k*8 +: 8] = mem_wdata[k*8 +: 8];
            bus_mem[int'(mem_addr >> 2)] = w;
          end else begin
            mem_rdata = rd_word(bus_mem, int'(mem_addr >> 2));
          end
        end else begin
          cnt++;
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one M-stage instruction and hold it until it retires.
  task automatic do_op(input logic rd, input logic wr, input logic sb,
                       input logic [31:0] a, input logic [31:0] d,
                       output int stalls, output logic [31:0] rdata,
                       output logic [31:0] exp_rdata);
    bus_t        e;
    logic [31:0] w;
    memreadM = rd;
    memwriteM = wr;
    sbM = sb;
    aluoutM = a;
    writedataM = d;
    exp_rdata = 32'h0;
    if (rd) begin
      e.we = 1'b0; e.addr = {a[31:2], 2'b00}; e.be = 4'h0; e.wdata = 32'h0;
      exp_q.push_back(e);
      exp_rdata = rd_word(model_mem, int'(a >> 2));
    end else if (wr) begin
      e.we = 1'b1; e.addr = {a[31:2], 2'b00};
      if (sb) begin
        for (int k = 0; k < 4; k++) e.be[k] = (k == int'(a[1:0]));
        e.wdata = {d[7:0], d[7:0], d[7:0], d[7:0]};
      end else begin
        e.be = 4'hF;
        e.wdata = d;
      end
      exp_q.push_back(e);
      w = rd_word(model_mem, int'(a >> 2));
      for (int k = 0; k < 4; k++)
        if (e.be[k]) w[k*8 +: 8] = e.wdata[k*8 +: 8];
      model_mem[int'(a >> 2)] = w;
    end
    stalls = 0;
    rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!memstallM) begin
        rdata = readdataM;
        @(posedge clk);
        #1;
        break;
      end
      stalls++;
      if (stalls > 300) begin
        checks++;
        errors++;
        $display("FAIL op_timeout: still stalled after %0d cycles, expected retirement", stalls);
        break;
      end
    end
    memreadM = 1'b0;
    memwriteM = 1'b0;
    sbM = 1'b0;
  endtask

  task automatic wait_bus_idle();
    int n;
    n = 0;
    while ((mem_req || exp_q.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (mem_req || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bus_idle: req=%b pending=%0d expected req=0 pending=0", mem_req, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    memreadM = 1'b0; memwriteM = 1'b0; sbM = 1'b0;
    aluoutM = 32'h0; writedataM = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, readdataM, memstallM} !== '0) begin
        errors++;
        $display("FAIL reset_state: req=%b we=%b addr=%h wdata=%h be=%h rdata=%h stall=%b expected all 0",
                 mem_req, mem_we, mem_addr, mem_wdata, mem_be, readdataM, memstallM);
      end
    end
  endtask

  task automatic test_store_word();
    int stalls;
    logic [31:0] rdata, er;
    fixed_wait = 0;
    @(posedge clk); #1;
    do_op(1'b0, 1'b1, 1'b0, 32'h104, 32'hDEADBEEF, stalls, rdata, er);
    checks++;
    if (stalls !== 0) begin
      errors++;
      $display("FAIL sw_stall: got %0d expected 0", stalls);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h104 ||
        mem_be !== 4'hF || mem_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_bus: req=%b we=%b addr=%h be=%h wdata=%h expected 1 1 00000104 f deadbeef",
               mem_req, mem_we, mem_addr, mem_be, mem_wdata);
    end
    wait_bus_idle();
  endtask

  task automatic test_store_byte();
    int stalls;
    logic [31:0] rdata, er;
    fixed_wait = 0;
    @(posedge clk); #1;
    do_op(1'b0, 1'b1, 1'b1, 32'h203, 32'h0000005A, stalls, rdata, er);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 ||
        mem_be !== 4'b1000 || mem_wdata !== 32'h5A5A5A5A) begin
      errors++;
      $display("FAIL sb_bus: req=%b we=%b addr=%h be=%b wdata=%h expected 1 1 00000200 1000 5a5a5a5a",
               mem_req, mem_we, mem_addr, mem_be, mem_wdata);
    end
    wait_bus_idle();
  endtask

  task automatic test_load_wait();
    int stalls;
    logic [31:0] rdata, er;
    bus_mem[16] = 32'h12345678;
    model_mem[16] = 32'h12345678;
    fixed_wait = 2;
    @(posedge clk); #1;
    do_op(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, stalls, rdata, er);
    checks++;
    if (stalls !== 4) begin
      errors++;
      $display("FAIL lw_wait2_stalls: got %0d expected 4", stalls);
    end
    checks++;
    if (rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL lw_wait2_data: got %h expected 12345678", rdata);
    end
    @(negedge clk);
    checks++;
    if (readdataM !== 32'h12345678 || mem_req !== 1'b0 || memstallM !== 1'b0) begin
      errors++;
      $display("FAIL lw_hold: rdata=%h req=%b stall=%b expected 12345678 0 0", readdataM, mem_req, memstallM);
    end
    // Zero-wait load straight after: proves the FSM is back in IDLE.
    fixed_wait = 0;
    @(posedge clk); #1;
    do_op(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, stalls, rdata, er);
    checks++;
    if (stalls !== 2 || rdata !== er) begin
      errors++;
      $display("FAIL lw_wait0: stalls=%0d data=%h expected 2 %h", stalls, rdata, er);
    end
    wait_bus_idle();
  endtask

  task automatic test_store_then_load();
    int stalls;
    logic [31:0] rdata, er;
    fixed_wait = 1;
    @(posedge clk); #1;
    do_op(1'b0, 1'b1, 1'b0, 32'h80, 32'h11, stalls, rdata, er);
    checks++;
    if (stalls !== 0) begin
      errors++;
      $display("FAIL st_ld_store_stall: got %0d expected 0", stalls);
    end
    do_op(1'b1, 1'b0, 1'b0, 32'h80, 32'h0, stalls, rdata, er);
    checks++;
    if (rdata !== 32'h00000011) begin
      errors++;
      $display("FAIL st_ld_data: got %h expected 00000011", rdata);
    end
    // Drain of 2 cycles + 1 on top of a 3-stall load with one wait cycle.
    checks++;
    if (stalls !== 6) begin
      errors++;
      $display("FAIL st_ld_stalls: got %0d expected 6", stalls);
    end
    wait_bus_idle();
  endtask

  task automatic test_back_to_back();
    int stalls, n;
    logic [31:0] rdata, er;
    bus_t e;
    fixed_wait = 3;
    @(posedge clk); #1;
    do_op(1'b0, 1'b1, 1'b0, 32'h300, 32'hA5A5_0001, stalls, rdata, er);
    checks++;
    if (stalls !== 0) begin
      errors++;
      $display("FAIL b2b_first_stall: got %0d expected 0", stalls);
    end
    do_op(1'b0, 1'b1, 1'b0, 32'h304, 32'hA5A5_0002, stalls, rdata, er);
    checks++;
    if (stalls !== 4) begin
      errors++;
      $display("FAIL b2b_second_stall: got %0d expected 4", stalls);
    end
    // Long read, interrupted by reset while it waits on the bus.
    fixed_wait = 20;
    memreadM = 1'b1;
    aluoutM = 32'h308;
    e.we = 1'b0; e.addr = 32'h308; e.be = 4'h0; e.wdata = 32'h0;
    exp_q.push_back(e);
    n = 0;
    while (!(mem_req && !mem_we) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(mem_req && !mem_we)) begin
      errors++;
      $display("FAIL b2b_read_start: req=%b we=%b expected 1 0", mem_req, mem_we);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    memreadM = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || memstallM !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: req=%b stall=%b expected 0 0", mem_req, memstallM);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || memstallM !== 1'b0 || readdataM !== 32'h0) begin
        errors++;
        $display("FAIL reset_after: req=%b stall=%b rdata=%h expected 0 0 0", mem_req, memstallM, readdataM);
      end
    end
    // Empty buffer after reset: a store must not stall.
    fixed_wait = 0;
    @(posedge clk); #1;
    do_op(1'b0, 1'b1, 1'b0, 32'h30C, 32'hCAFE_F00D, stalls, rdata, er);
    checks++;
    if (stalls !== 0) begin
      errors++;
      $display("FAIL reset_buf_empty: store stalls=%0d expected 0", stalls);
    end
    wait_bus_idle();
  endtask

  task automatic test_random();
    int stalls, r;
    logic [31:0] rdata, er, a, d;
    fixed_wait = -1;
    @(posedge clk); #1;
    for (int i = 0; i < 120; i++) begin
      r = int'($urandom_range(0, 9));
      a = 32'($urandom_range(0, 63));
      d = $urandom;
      if (r <= 3) begin
        do_op(1'b1, 1'b0, 1'b0, a, d, stalls, rdata, er);
      end else if (r <= 6) begin
        do_op(1'b0, 1'b1, 1'b0, a, d, stalls, rdata, er);
      end else if (r <= 8) begin
        do_op(1'b0, 1'b1, 1'b1, a, d, stalls, rdata, er);
      end else begin
        do_op(1'b1, 1'b1, 1'($urandom_range(0, 1)), a, d, stalls, rdata, er);
      end
      if (r <= 3 || r == 9) begin
        checks++;
        if (rdata !== er) begin
          errors++;
          $display("FAIL rand_load[%0d]: addr=%h got %h expected %h", i, a, rdata, er);
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    wait_bus_idle();
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_byte();
    test_load_wait();
    test_store_then_load();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
